// File: rtl/pass_sched_pkg.sv
// pass_sched_pkg: state encoding and pass geometry shared by pass_sched and pass_addr_gen.
package pass_sched_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    // Address value that marks "no valid row/column".
    function automatic int sentinel(input int s);
        return s;
    endfunction

    // Non-stalled RUN cycles per pass: steps k = 0..S.
    function automatic int pass_len(input int s);
        return s + 1;
    endfunction

endpackage

// File: rtl/pass_addr_gen.sv
// pass_addr_gen: step counter k with registered row address and column address skewed one step behind.
module pass_addr_gen
    import pass_sched_pkg::*;
#(
    parameter int S     = 8,
    parameter int ADDRW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic             i_run_nxt,
    output logic             o_last,
    output logic [ADDRW:0]   o_addr_r,
    output logic [ADDRW:0]   o_addr_c,
    output logic             o_k0
);

    localparam logic [ADDRW:0] SENT   = (ADDRW+1)'(sentinel(S));
    localparam logic [ADDRW:0] K_LAST = (ADDRW+1)'(pass_len(S) - 1);
    localparam logic [ADDRW:0] ONE    = (ADDRW+1)'(1);

    logic [ADDRW:0] r_k;
    logic [ADDRW:0] r_addr_r;
    logic [ADDRW:0] r_addr_c;
    logic           r_k0;
    logic [ADDRW:0] w_k_nxt;
    logic [ADDRW:0] w_ar_nxt;
    logic [ADDRW:0] w_ac_nxt;

    // Outputs are computed from the next k so they line up with k in the same cycle.
    always_comb begin
        w_k_nxt  = i_clear ? '0 : (i_step ? r_k + ONE : r_k);
        w_ar_nxt = (i_run_nxt && w_k_nxt < SENT) ? w_k_nxt : SENT;
        w_ac_nxt = (i_run_nxt && w_k_nxt != '0) ? w_k_nxt - ONE : SENT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k      <= '0;
            r_addr_r <= SENT;
            r_addr_c <= SENT;
            r_k0     <= 1'b0;
        end else begin
            r_k      <= w_k_nxt;
            r_addr_r <= w_ar_nxt;
            r_addr_c <= w_ac_nxt;
            r_k0     <= i_run_nxt && (w_k_nxt == '0);
        end
    end

    assign o_last   = (r_k == K_LAST);
    assign o_addr_r = r_addr_r;
    assign o_addr_c = r_addr_c;
    assign o_k0     = r_k0;

endmodule

// File: rtl/pass_sched.sv
// pass_sched: IDLE/RUN/DONE job scheduler issuing S+1-step passes back to back.
// Stall support is compiled in only when PASS_SCHED_STALL_EN is defined.
module pass_sched
    import pass_sched_pkg::*;
#(
    parameter int S     = 8,
    parameter int ADDRW = 3,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PW-1:0]    num_passes,
    input  logic             stall,
    output logic [ADDRW:0]   addr_r,
    output logic [ADDRW:0]   addr_c,
    output logic             acc_clr,
    output logic             busy,
    output logic             finished
);

    localparam logic [PW-1:0] ONE_P = PW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_p;
    logic [PW-1:0] r_np;
    logic          r_busy;
    logic          r_fin;
    logic          w_stall;
    logic          w_accept;
    logic          w_step;
    logic          w_end;
    logic          w_more;
    logic          w_last;
    logic          w_k0;
    logic          w_busy_nxt;
    logic          w_fin_nxt;

`ifdef PASS_SCHED_STALL_EN
    assign w_stall = stall;
`else
    logic w_unused_stall;
    assign w_unused_stall = stall;
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_accept    = (r_state != RUN) && start;
        w_step      = (r_state == RUN) && !w_stall;
        w_end       = w_step && w_last;
        w_more      = (r_p != r_np - ONE_P);
        w_state_nxt = w_accept ? RUN : ((w_end && !w_more) ? DONE : r_state);
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == RUN);
        w_fin_nxt  = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_np    <= ONE_P;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_fin   <= w_fin_nxt;
            if (w_accept) begin
                r_p  <= '0;
                r_np <= (num_passes == '0) ? ONE_P : num_passes;
            end else if (w_end && w_more) begin
                r_p <= r_p + ONE_P;
            end
        end
    end

    pass_addr_gen #(.S(S), .ADDRW(ADDRW)) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_accept || w_end),
        .i_step   (w_step),
        .i_run_nxt(w_busy_nxt),
        .o_last   (w_last),
        .o_addr_r (addr_r),
        .o_addr_c (addr_c),
        .o_k0     (w_k0)
    );

    // The k=0 flag persists through a stall; masking it keeps the pulse to one unstalled cycle.
    assign acc_clr  = w_k0 && !w_stall;
    assign busy     = r_busy;
    assign finished = r_fin;

endmodule

// File: tb/tb_pass_sched.sv
// tb_pass_sched: directed self-checking bench for pass_sched with S=8, ADDRW=3.
module tb_pass_sched;

    localparam int S     = 8;
    localparam int ADDRW = 3;
    localparam int PW    = 4;
`ifdef PASS_SCHED_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stall = 1'b0;
    logic [PW-1:0]    num_passes = '0;
    logic [ADDRW:0]   addr_r;
    logic [ADDRW:0]   addr_c;
    logic             acc_clr;
    logic             busy;
    logic             finished;
    int               n_chk = 0;
    int               n_pass = 0;

    always #5 clk = ~clk;

    pass_sched #(.S(S), .ADDRW(ADDRW), .PW(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_passes(num_passes),
        .stall     (stall),
        .addr_r    (addr_r),
        .addr_c    (addr_c),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .finished  (finished)
    );

    task automatic do_start(input int np);
        start = 1'b1;
        num_passes = 4'(np);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (addr_r !== 4'd8) $display("FAIL reset addr_r got %0d exp 8", addr_r); else n_pass++;
        n_chk++; if (addr_c !== 4'd8) $display("FAIL reset addr_c got %0d exp 8", addr_c); else n_pass++;
        n_chk++; if (acc_clr !== 1'b0) $display("FAIL reset acc_clr got %b exp 0", acc_clr); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (finished !== 1'b0) $display("FAIL reset finished got %b exp 0", finished); else n_pass++;
        reset = 1'b0;
        stall = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (addr_r !== 4'd8) $display("FAIL idle addr_r got %0d exp 8", addr_r); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL idle busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (acc_clr !== 1'b0) $display("FAIL idle acc_clr got %b exp 0", acc_clr); else n_pass++;
        stall = 1'b0;
    endtask

    task automatic test_job(input int np, input bit do_stall, input string tag);
        int n;
        int total;
        int t;
        int k;
        int clr_cnt;
        int busy_cnt;
        bit erun;
        bit eclr;
        logic [ADDRW:0] er;
        logic [ADDRW:0] ec;
        logic [63:0] mask;
        logic [63:0] emask;
        n = (np == 0) ? 1 : np;
        total = 9 * n + ((do_stall && STALL_EN) ? 3 : 0);
        clr_cnt = 0;
        busy_cnt = 0;
        mask = '0;
        emask = '0;
        for (int i = 0; i < n; i++) emask[1 + 9 * i] = 1'b1;
        do_start(np);
        for (int c = 1; c <= total + 2; c++) begin
            t = (do_stall && STALL_EN) ? ((c <= 5) ? c - 1 : ((c <= 8) ? 4 : c - 4)) : c - 1;
            k = t % 9;
            erun = (c <= total);
            er = (erun && k < 8) ? 4'(k) : 4'(8);
            ec = (erun && k >= 1) ? 4'(k - 1) : 4'(8);
            eclr = erun && (k == 0);
            n_chk++; if (addr_r !== er) $display("FAIL %s addr_r c=%0d got %0d exp %0d", tag, c, addr_r, er); else n_pass++;
            n_chk++; if (addr_c !== ec) $display("FAIL %s addr_c c=%0d got %0d exp %0d", tag, c, addr_c, ec); else n_pass++;
            n_chk++; if (acc_clr !== eclr) $display("FAIL %s acc_clr c=%0d got %b exp %b", tag, c, acc_clr, eclr); else n_pass++;
            n_chk++; if (busy !== erun) $display("FAIL %s busy c=%0d got %b exp %b", tag, c, busy, erun); else n_pass++;
            n_chk++; if (finished !== !erun) $display("FAIL %s finished c=%0d got %b exp %b", tag, c, finished, !erun); else n_pass++;
            if (acc_clr === 1'b1) begin
                clr_cnt++;
                mask[c] = 1'b1;
            end
            if (busy === 1'b1) busy_cnt++;
            stall = do_stall && c >= 5 && c <= 7;
            @(negedge clk);
        end
        stall = 1'b0;
        n_chk++; if (clr_cnt != n) $display("FAIL %s acc_clr_count got %0d exp %0d", tag, clr_cnt, n); else n_pass++;
        n_chk++; if (busy_cnt != total) $display("FAIL %s run_cycles got %0d exp %0d", tag, busy_cnt, total); else n_pass++;
        n_chk++; if (mask !== emask) $display("FAIL %s acc_clr_cycles got %h exp %h", tag, mask, emask); else n_pass++;
    endtask

    task automatic test_one_pass;
        test_job(1, 1'b0, "one_pass");
    endtask

    task automatic test_zero_passes;
        test_job(0, 1'b0, "zero_passes");
    endtask

    task automatic test_back_to_back;
        test_job(3, 1'b0, "back_to_back");
    endtask

    task automatic test_stall;
        test_job(1, 1'b1, "stall");
        stall = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (finished !== 1'b1) $display("FAIL stall_done finished got %b exp 1", finished); else n_pass++;
        n_chk++; if (addr_r !== 4'd8) $display("FAIL stall_done addr_r got %0d exp 8", addr_r); else n_pass++;
        stall = 1'b0;
    endtask

    task automatic test_start_mid_run;
        do_start(1);
        for (int c = 1; c <= 11; c++) begin
            n_chk++; if (busy !== (c <= 9)) $display("FAIL midstart busy c=%0d got %b exp %b", c, busy, c <= 9); else n_pass++;
            n_chk++; if (finished !== (c >= 10)) $display("FAIL midstart finished c=%0d got %b exp %b", c, finished, c >= 10); else n_pass++;
            if (c == 3) num_passes = 4'd5;
            start = (c == 3);
            @(negedge clk);
        end
        n_chk++; if (finished !== 1'b1) $display("FAIL done_hold finished got %b exp 1", finished); else n_pass++;
        do_start(2);
        n_chk++; if (finished !== 1'b0) $display("FAIL restart finished got %b exp 0", finished); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL restart busy got %b exp 1", busy); else n_pass++;
        n_chk++; if (acc_clr !== 1'b1) $display("FAIL restart acc_clr got %b exp 1", acc_clr); else n_pass++;
        n_chk++; if (addr_r !== 4'd0) $display("FAIL restart addr_r got %0d exp 0", addr_r); else n_pass++;
        repeat (9) @(negedge clk);
        n_chk++; if (acc_clr !== 1'b1) $display("FAIL restart pass2 acc_clr got %b exp 1", acc_clr); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL restart pass2 busy got %b exp 1", busy); else n_pass++;
        repeat (9) @(negedge clk);
        n_chk++; if (finished !== 1'b1) $display("FAIL restart end finished got %b exp 1", finished); else n_pass++;
    endtask

    task automatic test_async_reset;
        do_start(2);
        repeat (5) @(negedge clk);
        n_chk++; if (addr_r !== 4'd5) $display("FAIL prereset addr_r got %0d exp 5", addr_r); else n_pass++;
        n_chk++; if (addr_c !== 4'd4) $display("FAIL prereset addr_c got %0d exp 4", addr_c); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_chk++; if (addr_r !== 4'd8) $display("FAIL async_reset addr_r got %0d exp 8", addr_r); else n_pass++;
        n_chk++; if (addr_c !== 4'd8) $display("FAIL async_reset addr_c got %0d exp 8", addr_c); else n_pass++;
        n_chk++; if (acc_clr !== 1'b0) $display("FAIL async_reset acc_clr got %b exp 0", acc_clr); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL async_reset busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (finished !== 1'b0) $display("FAIL async_reset finished got %b exp 0", finished); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_chk++; if (finished !== 1'b0) $display("FAIL post_reset finished c=%0d got %b exp 0", c, finished); else n_pass++;
            n_chk++; if (busy !== 1'b0) $display("FAIL post_reset busy c=%0d got %b exp 0", c, busy); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_one_pass();
        test_zero_passes();
        test_back_to_back();
        test_stall();
        test_start_mid_run();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
